// File: rtl/tx_rx_pkg.sv
// Shared definitions for the Tx/Rx frame sequencer.
// Holds the data word width, the last generator count and the FSM state
// encoding, so the controller, its interface and any checkers agree.
package tx_rx_pkg;

    localparam int DATA_W = 10;
    localparam logic [DATA_W-1:0] MAX_COUNT = 10'd1023;

    // LATCH sits between ADVANCE and PRESENT so the word is captured only
    // after the generator has stepped.
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PRESENT   = 3'd1,
        WAIT_DONE = 3'd2,
        WAIT_RX   = 3'd3,
        ADVANCE   = 3'd4,
        LATCH     = 3'd5
    } seq_state_e;

endpackage

// File: rtl/tx_rx_seq_ctrl_if.sv
// Handshake bundle between the frame sequencer and its data generator,
// transmitter and receiver.
//   i_gen_count  generator value         o_gen_en    generator advance pulse
//   o_tx_data    word to transmit        o_tx_valid  Tx request (held)
//   i_tx_ready   Tx accepts              i_tx_done   serial Tx complete pulse
//   i_rx_valid   echo word strobe        i_rx_data   echoed word
// master: the sequencer side.  slave: the generator/Tx/Rx side.
interface tx_rx_seq_ctrl_if;
    import tx_rx_pkg::*;

    logic [DATA_W-1:0] i_gen_count;
    logic              o_gen_en;
    logic [DATA_W-1:0] o_tx_data;
    logic              o_tx_valid;
    logic              i_tx_ready;
    logic              i_tx_done;
    logic              i_rx_valid;
    logic [DATA_W-1:0] i_rx_data;

    modport master (
        input  i_gen_count, i_tx_ready, i_tx_done, i_rx_valid, i_rx_data,
        output o_gen_en, o_tx_data, o_tx_valid
    );

    modport slave (
        output i_gen_count, i_tx_ready, i_tx_done, i_rx_valid, i_rx_data,
        input  o_gen_en, o_tx_data, o_tx_valid
    );

endinterface

// File: rtl/seq_timeout_timer.sv
// Echo timeout counter.
//   i_clk     clock                 i_rst_n   async active-low reset
//   i_clear   restart count at 0    i_enable  count while waiting for echo
//   o_expire  high while enabled and the count sits at TIMEOUT_CYC-1
module seq_timeout_timer #(
    parameter int TIMEOUT_CYC = 20000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt_r;

    // Cycle counter; parks on LAST so it can never roll over.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_r <= '0;
        end else if (i_clear) begin
            cnt_r <= '0;
        end else if (i_enable && (cnt_r != LAST)) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

    assign o_expire = i_enable && (cnt_r == LAST);

endmodule

// File: rtl/tx_rx_seq_ctrl.sv
// Frame sequencer: takes a word from the data generator, hands it to the
// transmitter, waits for the serial completion and the loopback echo,
// scores the echo (match / mismatch / timeout) and steps the generator.
//   i_clk, i_rst_n  clock, async active-low reset
//   i_run           keep sequencing frames while high
//   bus             generator / Tx / Rx handshake (master side)
//   o_busy          not in IDLE
//   o_match_cnt     saturating count of matching echoes
//   o_err_cnt       saturating count of mismatches plus timeouts
//   o_timeout       one-cycle pulse on an echo timeout
//   o_wrap          one-cycle pulse when the 1023 frame completes
module tx_rx_seq_ctrl
    import tx_rx_pkg::*;
#(
    parameter int TIMEOUT_CYC = 20000,
    parameter int STAT_W      = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_run,
    tx_rx_seq_ctrl_if.master  bus,
    output logic              o_busy,
    output logic [STAT_W-1:0] o_match_cnt,
    output logic [STAT_W-1:0] o_err_cnt,
    output logic              o_timeout,
    output logic              o_wrap
);

    seq_state_e        state_r;
    seq_state_e        next_state_s;
    logic [DATA_W-1:0] tx_data_r;
    logic              tx_valid_r;
    logic              gen_en_r;
    logic              busy_r;
    logic              timeout_r;
    logic              wrap_r;
    logic [STAT_W-1:0] match_cnt_r;
    logic [STAT_W-1:0] err_cnt_r;
    logic              latch_s;
    logic              match_inc_s;
    logic              err_inc_s;
    logic              timeout_s;
    logic              tmr_clear_s;
    logic              tmr_en_s;
    logic              expire_s;

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (&v) ? v : (v + STAT_W'(1));
    endfunction

    seq_timeout_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timer (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_clear  (tmr_clear_s),
        .i_enable (tmr_en_s),
        .o_expire (expire_s)
    );

    // Next-state decode plus the per-cycle scoring strobes.
    always_comb begin
        next_state_s = state_r;
        latch_s      = 1'b0;
        match_inc_s  = 1'b0;
        err_inc_s    = 1'b0;
        timeout_s    = 1'b0;
        tmr_clear_s  = 1'b0;
        tmr_en_s     = (state_r == WAIT_RX);
        case (state_r)
            IDLE: begin
                if (i_run) begin
                    next_state_s = PRESENT;
                    latch_s      = 1'b1;
                end else begin
                    next_state_s = IDLE;
                end
            end
            PRESENT: begin
                if (tx_valid_r && bus.i_tx_ready) begin
                    next_state_s = WAIT_DONE;
                end else begin
                    next_state_s = PRESENT;
                end
            end
            WAIT_DONE: begin
                if (bus.i_tx_done) begin
                    next_state_s = WAIT_RX;
                    tmr_clear_s  = 1'b1;
                end else begin
                    next_state_s = WAIT_DONE;
                end
            end
            WAIT_RX: begin
                // An echo arriving on the expiry cycle still counts as an echo.
                if (bus.i_rx_valid) begin
                    next_state_s = ADVANCE;
                    if (bus.i_rx_data == tx_data_r) begin
                        match_inc_s = 1'b1;
                    end else begin
                        err_inc_s = 1'b1;
                    end
                end else if (expire_s) begin
                    next_state_s = ADVANCE;
                    timeout_s    = 1'b1;
                    err_inc_s    = 1'b1;
                end else begin
                    next_state_s = WAIT_RX;
                end
            end
            ADVANCE: begin
                if (i_run) begin
                    next_state_s = LATCH;
                end else begin
                    next_state_s = IDLE;
                end
            end
            LATCH: begin
                next_state_s = PRESENT;
                latch_s      = 1'b1;
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Registered outputs, decoded from the state being entered.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tx_valid_r  <= 1'b0;
            gen_en_r    <= 1'b0;
            wrap_r      <= 1'b0;
            busy_r      <= 1'b0;
            timeout_r   <= 1'b0;
            tx_data_r   <= '0;
            match_cnt_r <= '0;
            err_cnt_r   <= '0;
        end else begin
            tx_valid_r <= (next_state_s == PRESENT);
            gen_en_r   <= (next_state_s == ADVANCE);
            // tx_data_r only changes on a latch, so it still holds the sent word.
            wrap_r     <= (next_state_s == ADVANCE) && (tx_data_r == MAX_COUNT);
            busy_r     <= (next_state_s != IDLE);
            timeout_r  <= timeout_s;
            if (latch_s) begin
                tx_data_r <= bus.i_gen_count;
            end
            if (match_inc_s) begin
                match_cnt_r <= sat_inc(match_cnt_r);
            end
            if (err_inc_s) begin
                err_cnt_r <= sat_inc(err_cnt_r);
            end
        end
    end

    assign bus.o_tx_valid = tx_valid_r;
    assign bus.o_tx_data  = tx_data_r;
    assign bus.o_gen_en   = gen_en_r;
    assign o_busy         = busy_r;
    assign o_match_cnt    = match_cnt_r;
    assign o_err_cnt      = err_cnt_r;
    assign o_timeout      = timeout_r;
    assign o_wrap         = wrap_r;

endmodule

// File: tb/tb_tx_rx_seq_ctrl.sv
// Directed bench for tx_rx_seq_ctrl: a 10-bit generator model steps on
// o_gen_en, the Tx/Rx side is driven step by step from one initial block.
module tb_tx_rx_seq_ctrl;

    localparam int TO = 16;
    localparam int SW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          run;
    logic          busy;
    logic          timeout;
    logic          wrap;
    logic [SW-1:0] match_cnt;
    logic [SW-1:0] err_cnt;
    logic [9:0]    gen_count;
    logic          gen_load;
    logic [9:0]    gen_load_val;
    int            gen_pulses = 0;
    int            wrap_pulses = 0;
    int            checks = 0;
    int            errors = 0;

    tx_rx_seq_ctrl_if bus();

    tx_rx_seq_ctrl #(
        .TIMEOUT_CYC (TO),
        .STAT_W      (SW)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_run       (run),
        .bus         (bus),
        .o_busy      (busy),
        .o_match_cnt (match_cnt),
        .o_err_cnt   (err_cnt),
        .o_timeout   (timeout),
        .o_wrap      (wrap)
    );

    always #5 clk = ~clk;

    assign bus.i_gen_count = gen_count;

    // Data generator model: 10-bit counter advanced by o_gen_en.
    always @(posedge clk) begin
        if (gen_load) gen_count <= gen_load_val;
        else if (bus.o_gen_en) gen_count <= gen_count + 10'd1;
    end

    // Pulse tallies.
    always @(posedge clk) begin
        if (bus.o_gen_en === 1'b1) gen_pulses <= gen_pulses + 1;
        if (wrap === 1'b1) wrap_pulses <= wrap_pulses + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int max_cyc);
        int n;
        n = 0;
        while (bus.o_tx_valid !== 1'b1 && n < max_cyc) begin
            tick();
            n++;
        end
        check("tx_valid_seen", 32'(bus.o_tx_valid), 32'd1);
    endtask

    // One frame; returns #1 after the edge that enters ADVANCE.
    task automatic frame(input logic [9:0] word, input logic echo_on,
                         input logic [9:0] echo, input int delay);
        int n;
        wait_valid(8);
        check("tx_data", 32'(bus.o_tx_data), 32'(word));
        tick();
        check("valid_drop", 32'(bus.o_tx_valid), 32'd0);
        bus.i_tx_done = 1'b1;
        tick();
        bus.i_tx_done = 1'b0;
        if (echo_on) begin
            for (int i = 0; i < delay; i++) tick();
            bus.i_rx_valid = 1'b1;
            bus.i_rx_data  = echo;
            tick();
            bus.i_rx_valid = 1'b0;
            check("no_timeout", 32'(timeout), 32'd0);
        end else begin
            n = 0;
            while (timeout !== 1'b1 && n < 4 * TO) begin
                tick();
                n++;
            end
            check("timeout_latency", 32'(n), 32'(TO));
        end
        check("gen_en_advance", 32'(bus.o_gen_en), 32'd1);
        check("wrap_flag", 32'(wrap), 32'(word == 10'd1023));
    endtask

    initial begin
        rst_n          = 1'b0;
        run            = 1'b0;
        bus.i_tx_ready = 1'b1;
        bus.i_tx_done  = 1'b0;
        bus.i_rx_valid = 1'b0;
        bus.i_rx_data  = 10'd0;
        gen_load       = 1'b1;
        gen_load_val   = 10'd0;
        tick();
        tick();
        gen_load = 1'b0;

        // Reset state
        check("rst_tx_valid", 32'(bus.o_tx_valid), 32'd0);
        check("rst_gen_en", 32'(bus.o_gen_en), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        check("rst_wrap", 32'(wrap), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_tx_data", 32'(bus.o_tx_data), 32'd0);
        check("rst_match", 32'(match_cnt), 32'd0);
        check("rst_err", 32'(err_cnt), 32'd0);
        rst_n = 1'b1;
        tick();

        // Stray done/echo in IDLE are ignored
        bus.i_tx_done  = 1'b1;
        bus.i_rx_valid = 1'b1;
        tick();
        bus.i_tx_done  = 1'b0;
        bus.i_rx_valid = 1'b0;
        tick();
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_match", 32'(match_cnt), 32'd0);
        check("idle_err", 32'(err_cnt), 32'd0);

        // Loopback, words 0..2; ADVANCE->valid latency of 2 on the first
        run = 1'b1;
        frame(10'd0, 1'b1, 10'd0, 0);
        tick();
        check("latch_valid_low", 32'(bus.o_tx_valid), 32'd0);
        check("latch_busy", 32'(busy), 32'd1);
        tick();
        check("latency_valid", 32'(bus.o_tx_valid), 32'd1);
        frame(10'd1, 1'b1, 10'd1, 2);
        frame(10'd2, 1'b1, 10'd2, 0);
        tick();
        check("loop_match", 32'(match_cnt), 32'd3);
        check("loop_err", 32'(err_cnt), 32'd0);
        check("loop_gen_pulses", 32'(gen_pulses), 32'd3);

        // Corrupted echo on word 5
        frame(10'd3, 1'b1, 10'd3, 1);
        frame(10'd4, 1'b1, 10'd4, 0);
        frame(10'd5, 1'b1, 10'h3FF, 0);
        check("corrupt_err", 32'(err_cnt), 32'd1);
        tick();
        check("corrupt_gen_pulses", 32'(gen_pulses), 32'd6);
        frame(10'd6, 1'b1, 10'd6, 0);
        check("after_corrupt_match", 32'(match_cnt), 32'd6);

        // Timeout, then echo landing on the expiry cycle
        frame(10'd7, 1'b0, 10'd0, 0);
        check("timeout_err", 32'(err_cnt), 32'd2);
        tick();
        check("timeout_one_cycle", 32'(timeout), 32'd0);
        frame(10'd8, 1'b1, 10'd8, TO - 1);
        check("tie_match", 32'(match_cnt), 32'd7);
        check("tie_err", 32'(err_cnt), 32'd2);

        // Tx back-pressure for 10 cycles with stray strobes, then stop mid-frame
        bus.i_tx_ready = 1'b0;
        wait_valid(8);
        for (int i = 0; i < 10; i++) begin
            bus.i_tx_done  = (i == 2);
            bus.i_rx_valid = (i == 2);
            bus.i_rx_data  = 10'd9;
            tick();
            check("hold_valid", 32'(bus.o_tx_valid), 32'd1);
            check("hold_data", 32'(bus.o_tx_data), 32'd9);
        end
        bus.i_tx_done  = 1'b0;
        bus.i_rx_valid = 1'b0;
        check("stray_match", 32'(match_cnt), 32'd7);
        check("stray_err", 32'(err_cnt), 32'd2);
        bus.i_tx_ready = 1'b1;
        tick();
        check("hold_release_drop", 32'(bus.o_tx_valid), 32'd0);
        bus.i_tx_done = 1'b1;
        tick();
        bus.i_tx_done = 1'b0;
        run = 1'b0;
        tick();
        tick();
        bus.i_rx_valid = 1'b1;
        bus.i_rx_data  = 10'd9;
        tick();
        bus.i_rx_valid = 1'b0;
        check("stop_gen_en", 32'(bus.o_gen_en), 32'd1);
        tick();
        check("stop_busy", 32'(busy), 32'd0);
        check("stop_match", 32'(match_cnt), 32'd8);
        for (int i = 0; i < 5; i++) tick();
        check("stop_valid", 32'(bus.o_tx_valid), 32'd0);
        check("stop_gen_pulses", 32'(gen_pulses), 32'd10);

        // Generator wrap 1022, 1023, 0
        gen_load     = 1'b1;
        gen_load_val = 10'd1022;
        tick();
        gen_load = 1'b0;
        run = 1'b1;
        frame(10'd1022, 1'b1, 10'd1022, 0);
        frame(10'd1023, 1'b1, 10'd1023, 0);
        frame(10'd0, 1'b1, 10'd0, 0);
        tick();
        check("wrap_pulses", 32'(wrap_pulses), 32'd1);
        check("wrap_match", 32'(match_cnt), 32'd11);

        // Reset while waiting for the echo
        wait_valid(8);
        check("rst_frame_data", 32'(bus.o_tx_data), 32'd1);
        tick();
        bus.i_tx_done = 1'b1;
        tick();
        bus.i_tx_done = 1'b0;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(bus.o_tx_valid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_gen_en", 32'(bus.o_gen_en), 32'd0);
        check("mid_rst_match", 32'(match_cnt), 32'd0);
        check("mid_rst_tx_data", 32'(bus.o_tx_data), 32'd0);
        for (int i = 0; i < 3; i++) tick();
        check("mid_rst_gen_pulses", 32'(gen_pulses), 32'd13);
        rst_n = 1'b1;
        frame(10'd1, 1'b1, 10'd1, 0);
        check("resume_match", 32'(match_cnt), 32'd1);

        // Statistics saturation
        for (int w = 2; w < 16; w++) frame(10'(w), 1'b1, 10'(w), 0);
        check("match_full", 32'(match_cnt), 32'd15);
        frame(10'd16, 1'b1, 10'd16, 0);
        check("match_saturate", 32'(match_cnt), 32'd15);
        for (int w = 17; w < 33; w++) frame(10'(w), 1'b1, ~(10'(w)), 0);
        check("err_saturate", 32'(err_cnt), 32'd15);
        check("match_held", 32'(match_cnt), 32'd15);
        run = 1'b0;
        tick();
        check("final_busy", 32'(busy), 32'd0);
        check("final_gen_pulses", 32'(gen_pulses), 32'd45);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
